// File: rtl/logic_slice_sequencer_if.sv
// rtl/logic_slice_sequencer_if.sv - request/response/slice bundle for logic_slice_sequencer (LOGIC_SEQ_ZERO_FLAG_EN adds rsp_zero)
interface logic_slice_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [DATA_W-1:0]  req_a;
  logic [DATA_W-1:0]  req_b;
  logic               slice_en;
  logic [1:0]         slice_op;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  logic               rsp_zero;
`endif

  modport slave (
    input  req_valid, req_op, req_a, req_b, slice_y, rsp_ready,
    output req_ready, slice_en, slice_op, slice_a, slice_b, rsp_valid, rsp_data
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    , output rsp_zero
`endif
  );

  modport master (
    output req_valid, req_op, req_a, req_b, slice_y, rsp_ready,
    input  req_ready, slice_en, slice_op, slice_a, slice_b, rsp_valid, rsp_data
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    , input rsp_zero
`endif
  );
endinterface

// File: rtl/logic_slice_sequencer.sv
// rtl/logic_slice_sequencer.sv - sequences 32-bit AND/OR/XOR/NOR through a narrow shared logic slice, LSB chunk first
// Optional LOGIC_SEQ_ZERO_FLAG_EN adds a registered rsp_zero flag.
module logic_slice_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  logic_slice_sequencer_if.slave  bus
);
  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int KW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  logic                zero_q, zero_d;
`endif

  logic                req_ready;
  logic                rsp_valid;
  logic                slice_en;
  logic [1:0]          slice_op;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      zero_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      zero_q     <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    zero_d     = zero_q;
`endif
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    slice_en   = 1'b0;
    slice_op   = '0;
    slice_a    = '0;
    slice_b    = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        slice_en = 1'b1;
        slice_op = op_q;
        slice_a  = a_q[k_q*SLICE_W +: SLICE_W];
        slice_b  = b_q[k_q*SLICE_W +: SLICE_W];
        acc_d[k_q*SLICE_W +: SLICE_W] = bus.slice_y;
        // The last chunk is merged combinationally so rsp_data is complete on this edge.
        if (k_q == K_LAST) begin
          rsp_data_d = acc_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          zero_d     = (acc_d == '0);
`endif
          k_d        = '0;
          state_d    = RESP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.slice_en  = slice_en;
  assign bus.slice_op  = slice_op;
  assign bus.slice_a   = slice_a;
  assign bus.slice_b   = slice_b;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  assign bus.rsp_zero  = zero_q;
`endif
endmodule

// File: tb/tb_logic_slice_sequencer.sv
// tb/tb_logic_slice_sequencer.sv - directed-vector bench for logic_slice_sequencer
module tb_logic_slice_sequencer;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  logic_slice_sequencer_if #(.DATA_W(32), .SLICE_W(8)) bus ();

  logic_slice_sequencer #(.DATA_W(32), .SLICE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared slice.
  always_comb begin
    bus.slice_y = '0;
    case (bus.slice_op)
      2'b00: bus.slice_y = bus.slice_a & bus.slice_b;
      2'b01: bus.slice_y = bus.slice_a | bus.slice_b;
      2'b10: bus.slice_y = bus.slice_a ^ bus.slice_b;
      2'b11: bus.slice_y = ~(bus.slice_a | bus.slice_b);
      default: bus.slice_y = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit rdy, input bit clobber);
    int cnt;
    @(negedge clk);
    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = rdy;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        bus.req_valid = 1'b0;
        if (clobber) begin
          bus.req_a  = '0;
          bus.req_op = 2'b00;
        end
        chk("slice_op", 32'(bus.slice_op), 32'(op));
      end
      if (cnt >= 1 && cnt <= 4) begin
        chk("slice_en", 32'(bus.slice_en), 32'd1);
        chk("slice_a", 32'(bus.slice_a), 32'(a[(cnt-1)*8 +: 8]));
        chk("slice_b", 32'(bus.slice_b), 32'(b[(cnt-1)*8 +: 8]));
      end
    end while (!bus.rsp_valid && cnt < 20);
    chk("latency", 32'(cnt - 1), 32'd4);
    chk("rsp_data", bus.rsp_data, exp);
    chk("slice_en_resp", 32'(bus.slice_en), 32'd0);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(exp == 32'd0));
`endif
    if (rdy) begin
      @(negedge clk);
      chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
      chk("req_ready_after", 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] bb_a [3];
    logic [31:0] bb_b [3];
    logic [1:0]  bb_op [3];
    logic [31:0] bb_exp [3];
    int          acc_t [3];
    int          ai;
    int          ri;

    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_slice_en", 32'(bus.slice_en), 32'd0);
    end
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    chk("rst_rsp_zero", 32'(bus.rsp_zero), 32'd1);
`endif
    rst_n = 1'b1;

    do_op(2'b01, 32'h12345678, 32'h0F0F0F0F, 32'h1F3F5F7F, 1'b1, 1'b0);
    do_op(2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_op(2'b00, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0);

    // Backpressure with operand clobbering after acceptance.
    do_op(2'b10, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h11111111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_data", bus.rsp_data, 32'h55555555);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("bp_no_accept", 32'(bus.req_ready), 32'd1);
    chk("bp_data_kept", bus.rsp_data, 32'h55555555);
    @(negedge clk);
    chk("bp_no_run", 32'(bus.slice_en), 32'd0);

    // Mid-operation reset after two chunks have been captured.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_a     = 32'hDEADBEEF;
    bus.req_b     = 32'h01234567;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_slice_en", 32'(bus.slice_en), 32'd0);
    chk("mrst_slice_a", 32'(bus.slice_a), 32'd0);
    chk("mrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mrst_rsp_data", bus.rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    do_op(2'b01, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Back-to-back with req_valid held high.
    bb_op[0] = 2'b00; bb_a[0] = 32'hFF00FF00; bb_b[0] = 32'h0FF00FF0; bb_exp[0] = 32'h0F000F00;
    bb_op[1] = 2'b01; bb_a[1] = 32'h00000001; bb_b[1] = 32'h80000000; bb_exp[1] = 32'h80000001;
    bb_op[2] = 2'b10; bb_a[2] = 32'h12345678; bb_b[2] = 32'hFFFFFFFF; bb_exp[2] = 32'hEDCBA987;
    ai = 0;
    ri = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        if (ri < 3) chk("b2b_data", bus.rsp_data, bb_exp[ri]);
        ri++;
      end
      if (ai < 3) begin
        bus.req_valid = 1'b1;
        bus.req_op    = bb_op[ai];
        bus.req_a     = bb_a[ai];
        bus.req_b     = bb_b[ai];
        if (bus.req_ready) begin
          acc_t[ai] = c;
          ai++;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    chk("b2b_accepts", 32'(ai), 32'd3);
    chk("b2b_results", 32'(ri), 32'd3);
    if (ai == 3) begin
      chk("b2b_gap01", 32'(acc_t[1] - acc_t[0]), 32'd6);
      chk("b2b_gap12", 32'(acc_t[2] - acc_t[1]), 32'd6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
